// File: rtl/byte_adder_pkg.sv
// Shared definitions for the byte-serial multi-precision adder.
//   BYTE_W  : width of one operand/sum byte
//   state_t : sequencer states (IDLE = byte 0 expected, RUN = mid-word)
//   idx_w() : width of the byte index register for a given word size
package byte_adder_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Clamped to 1 so that a degenerate word size never yields a zero-width index.
   function automatic int idx_w(input int nbytes);
      return (nbytes <= 2) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/adder8bit.sv
// 8-bit ripple-carry adder.
//   a, b : operand bytes
//   cin  : carry into bit 0
//   sum  : 8-bit sum
//   cout : carry out of bit 7
module adder8bit
   import byte_adder_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial multi-precision adder sequencer.
// Operands arrive LSB byte first as (in_a, in_b) pairs; each pair goes through
// adder8bit with the carry chained between bytes in a register. Results leave
// through a one-entry output register with a final word carry.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous abort of the current word and pending output
//   in_valid/in_ready   : input handshake; in_a, in_b operand bytes
//   in_cin              : word carry-in, used only on byte 0
//   out_valid/out_ready : output handshake; out_sum sum byte
//   out_last            : sum byte is byte NBYTES-1
//   out_cout            : word carry-out, only non-zero with out_last
//   out_ovf             : two's-complement word overflow (only with OVERFLOW_EN)
// Build option: define OVERFLOW_EN to add the out_ovf port and its logic.
module byte_serial_adder
   import byte_adder_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_a,
   input  logic [BYTE_W-1:0] in_b,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_sum,
   output logic              out_last,
`ifdef OVERFLOW_EN
   output logic              out_ovf,
`endif
   output logic              out_cout
);

   localparam int            IW       = idx_w(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              carry_q;
   logic              in_fire, out_fire, is_last, add_cin, add_cout;
   logic [BYTE_W-1:0] add_sum;

   // One-entry output register: a new byte may enter whenever the register
   // is empty or is being drained this same cycle.
   assign in_ready = !out_valid || out_ready;
   // clr discards any input presented in its cycle.
   assign in_fire  = in_valid && in_ready && !clr;
   assign out_fire = out_valid && out_ready;
   assign is_last  = (idx_q == LAST_IDX);
   // Byte 0 always takes the word carry-in, so no carry leaks across words.
   assign add_cin  = (state_q == IDLE) ? in_cin : carry_q;

   adder8bit u_add (
      .a    (in_a),
      .b    (in_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (clr) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (in_fire) begin
         idx_d = is_last ? '0 : idx_q + IW'(1);
         case (state_q)
            IDLE:    state_d = is_last ? IDLE : RUN;
            RUN:     state_d = is_last ? IDLE : RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q   <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
      end else if (clr) begin
         carry_q   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
      end else if (in_fire) begin
         carry_q   <= add_cout;
         out_valid <= 1'b1;
         out_sum   <= add_sum;
         out_last  <= is_last;
         out_cout  <= is_last & add_cout;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OVERFLOW_EN
   // Signed overflow: operands share a sign bit but the top sum byte does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ovf <= 1'b0;
      end else if (clr) begin
         out_ovf <= 1'b0;
      end else if (in_fire) begin
         out_ovf <= is_last && (in_a[BYTE_W-1] == in_b[BYTE_W-1]) &&
                    (add_sum[BYTE_W-1] != in_a[BYTE_W-1]);
      end
   end
`endif

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder (NBYTES=4): word vectors from a
// table, a scoreboard queue of expected sum bytes, plus stall and clr sequences.
module tb_byte_serial_adder;

   localparam int NB = 4;

   logic       clk, rst_n, clr, in_valid, in_ready, in_cin;
   logic [7:0] in_a, in_b, out_sum;
   logic       out_valid, out_ready, out_last, out_cout;
`ifdef OVERFLOW_EN
   logic       out_ovf;
`endif

   byte_serial_adder #(.NBYTES(NB)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_last(out_last),
`ifdef OVERFLOW_EN
      .out_ovf(out_ovf),
`endif
      .out_cout(out_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b;
      logic        cin;
      logic [31:0] sum;
      logic        cout, ovf;
   } vec_t;

   typedef struct packed {
      logic [7:0] sum;
      logic       last, cout, ovf;
   } exp_t;

   vec_t tbl[8];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   hold_prev = 0;
   exp_t held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic drive_byte(input logic [7:0] a, input logic [7:0] b, input logic cin,
                             input exp_t e);
      int waited = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            @(posedge clk); #1;
            break;
         end
         waited++;
         if (waited > 50) begin
            n_checks++; n_fail++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0 for %0d cycles", waited);
            break;
         end
      end
   endtask

   task automatic drive_word(input int k);
      exp_t e;
      logic [31:0] a, b, s;
      a = tbl[k].a; b = tbl[k].b; s = tbl[k].sum;
      for (int i = 0; i < NB; i++) begin
         e.sum  = s[8*i +: 8];
         e.last = (i == NB-1);
         e.cout = (i == NB-1) ? tbl[k].cout : 1'b0;
         e.ovf  = (i == NB-1) ? tbl[k].ovf  : 1'b0;
         drive_byte(a[8*i +: 8], b[8*i +: 8], (i == 0) ? tbl[k].cin : 1'b0, e);
      end
      in_valid = 1'b0;
   endtask

   // Output monitor: scoreboard compare, hold stability and back-pressure.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold_prev && out_valid) begin
               chk("hold_sum",  out_sum,  held.sum);
               chk("hold_last", out_last, held.last);
               chk("hold_cout", out_cout, held.cout);
            end
            if (out_valid && !out_ready)
               chk("in_ready_stall", in_ready, 1'b0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL spurious_out: sum %h with empty scoreboard", out_sum);
               end else begin
                  e = sb.pop_front();
                  chk("out_sum",  out_sum,  e.sum);
                  chk("out_last", out_last, e.last);
                  chk("out_cout", out_cout, e.cout);
`ifdef OVERFLOW_EN
                  chk("out_ovf",  out_ovf,  e.ovf);
`endif
               end
            end
            hold_prev = out_valid && !out_ready && !clr;
            held.sum  = out_sum; held.last = out_last; held.cout = out_cout;
         end
      end
   end

   initial begin
      time t0;
      exp_t dummy;
      int   tmo;
      tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
      tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
      tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      tbl[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[4] = '{32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0};
      tbl[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
      tbl[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0};
      tbl[7] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = 8'h00; in_b = 8'h00; in_cin = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sum",   out_sum,   8'h00);
      chk("rst_out_last",  out_last,  1'b0);
      chk("rst_out_cout",  out_cout,  1'b0);
`ifdef OVERFLOW_EN
      chk("rst_out_ovf",   out_ovf,   1'b0);
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // All words back to back at full rate: one byte per clock.
      t0 = $time;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         drive_word(k);
         in_valid = (k < 7);
      end
      in_valid = 1'b0;
      chk("throughput_cycles", 32'(($time - t0) / 10), 32'(8 * NB));

      // Downstream stall of 3 clocks after byte 1 leaves the adder.
      fork
         drive_word(6);
         begin
            @(posedge clk); @(posedge clk); #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join

      // clr mid-word: pending output dropped, carry and index restart.
      drive_byte(8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b0, 1'b0, 1'b0});
      drive_byte(8'hFF, 8'hFF, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0});
      out_ready = 1'b0; clr = 1'b1;
      in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("clr_out_valid", out_valid, 1'b0);
      chk("clr_out_last",  out_last,  1'b0);
      chk("clr_out_cout",  out_cout,  1'b0);
      chk("clr_in_ready",  in_ready,  1'b1);
      while (sb.size() > 0) dummy = sb.pop_front();
      out_ready = 1'b1;
      @(posedge clk); #1;
      drive_word(4);

      tmo = 0;
      while ((sb.size() != 0 || out_valid) && tmo < 50) begin
         @(posedge clk); #1; tmo++;
      end
      chk("drain_sb_left", 32'(sb.size()), 32'd0);
      @(negedge clk);
      chk("drain_out_valid", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
